rv_decode_stage: RTL and testbench
==================================

# rv_decode_stage

Registered instruction-decode stage producing the operand selects, immediate and 4-bit ALU operation code consumed by the execute-stage ALU. Sits between fetch and execute in the RV32I pipeline and accepts one instruction per cycle over a valid/ready handshake. It holds its output register under downstream back-pressure and clears it on a pipeline flush.

## Interface

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage can accept this cycle (combinational)
- in_instr  in  32  RV32I instruction word
- in_pc  in  32  PC of in_instr
- flush  in  1  discard the held output and any instruction presented this cycle
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute accepts the bundle
- out_pc  out  32  registered PC
- alu_sel  out  4  0 add, 1 sub, 2 and, 3 or, 4 sll, 5 srl, 6 xor, 7 slt, 8 sltu, 10 sra; 9 is never emitted
- a_sel  out  1  ALU inp1 source: 0 rs1, 1 pc
- b_sel  out  1  ALU inp2 source: 0 rs2, 1 imm
- imm  out  32  sign-extended immediate
- rs1, rs2, rd  out  5 each  register indices
- funct3  out  3  raw funct3, used by branch and memory units
- reg_wen, mem_rd, mem_wr, branch, jump  out  1 each  control flags
- illegal  out  1  undecodable instruction

## Operation

- Handshake: in_ready = !out_valid | out_ready | flush. A transfer occurs when in_valid & in_ready.
- Register update priority is flush > transfer > output accepted (out_valid & out_ready sets out_valid=0) > hold.
- flush: out_valid is 0 next cycle and any coincident input is dropped.
- Hold: while out_valid & !out_ready, every output stays bit-stable.
- Decode by opcode [6:0]:
  - OP 0110011: a_sel=0, b_sel=0, reg_wen=1. funct7 0x00 selects add/sll/slt/sltu/xor/srl/or/and by funct3 0..7. funct7 0x20 is legal only with funct3 000 (sub) or 101 (sra).
  - OP-IMM 0010011: b_sel=1, reg_wen=1, same funct3 map (no subi). funct3 001 requires funct7 0x00. funct3 101 requires funct7 0x00 (srl) or 0x20 (sra). For shifts, imm = zero-extended instr[24:20].
  - LOAD 0000011: add, b_sel=1, I-imm, mem_rd=1, reg_wen=1.
  - STORE 0100011: add, b_sel=1, S-imm, mem_wr=1, rd=0.
  - BRANCH 1100011: add, a_sel=1, b_sel=1, B-imm, branch=1. Comparison is done by the branch unit using rs1/rs2/funct3.
  - LUI 0110111: add, rs1 forced to 0, b_sel=1, U-imm, reg_wen=1.
  - AUIPC 0010111: add, a_sel=1, b_sel=1, U-imm, reg_wen=1.
  - JAL 1101111: add, a_sel=1, b_sel=1, J-imm, jump=1, reg_wen=1.
  - JALR 1100111 (funct3 000 only): add, b_sel=1, I-imm, jump=1, reg_wen=1.
- Any other opcode or encoding: illegal=1, alu_sel=0, and reg_wen, mem_rd, mem_wr, branch and jump all 0. out_valid is still asserted so the exception path sees the instruction.
- rd with reg_wen=1 and rd=0 is legal; reg_wen stays 1 and the regfile ignores x0 writes.

## Timing

- Latency: 1 cycle. An instruction accepted at edge N is visible on the outputs after edge N.
- Throughput: 1 per cycle while out_ready=1.
- Reset (rst_n=0, asynchronous): out_valid=0 and all registered outputs 0, including alu_sel=0, imm=0, illegal=0 and out_pc=0. in_ready=1 immediately.
- Reset mid-operation: the held bundle is lost with no partial state. The first transfer is possible on the first edge after rst_n rises.
- Simultaneous accept and new input (out_valid & out_ready & in_valid): the new bundle replaces the old one with no bubble.
- flush with out_ready=0: the held bundle is still dropped.

## Test plan

- add x3,x1,x2 (0x002081B3), out_ready=1 -> next cycle: out_valid=1, alu_sel=0, rs1=1, rs2=2, rd=3, a_sel=0, b_sel=0, reg_wen=1.
- sub x5,x6,x7 (0x407302B3), then srai x4,x4,3 (0x40325213) back-to-back -> alu_sel=1 and then alu_sel=10 with imm=3, b_sel=1, on consecutive cycles with no bubble.
- lw x1,-4(x2) (0xFFC12083) -> imm=0xFFFFFFFC, mem_rd=1, reg_wen=1, alu_sel=0, b_sel=1.
- Back-pressure: out_valid=1, hold out_ready=0 for 3 cycles with a new in_valid pending -> in_ready=0 and outputs unchanged for all 3 cycles. The new bundle appears one cycle after out_ready returns to 1.
- flush asserted together with in_valid and in_instr=0x002081B3 -> out_valid=0 next cycle. A subsequent instruction decodes normally.
- 0xFFFFFFFF, then slli with funct7=0x20 (0x40109093) -> illegal=1, reg_wen=0, mem_wr=0, out_valid=1 for each. Asserting rst_n=0 mid-stream clears out_valid asynchronously.

Source files
------------

// File: rtl/rv_decode_stage.sv
// RV32I registered decode stage: turns an instruction word into ALU operand
// selects, immediate, ALU op code and control flags behind a valid/ready
// handshake.
module rv_decode_stage #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [3:0]      alu_sel,
   output logic            a_sel,
   output logic            b_sel,
   output logic [XLEN-1:0] imm,
   output logic [4:0]      rs1,
   output logic [4:0]      rs2,
   output logic [4:0]      rd,
   output logic [2:0]      funct3,
   output logic            reg_wen,
   output logic            mem_rd,
   output logic            mem_wr,
   output logic            branch,
   output logic            jump,
   output logic            illegal
);

   localparam logic [6:0] OpcOp     = 7'b0110011;
   localparam logic [6:0] OpcOpImm  = 7'b0010011;
   localparam logic [6:0] OpcLoad   = 7'b0000011;
   localparam logic [6:0] OpcStore  = 7'b0100011;
   localparam logic [6:0] OpcBranch = 7'b1100011;
   localparam logic [6:0] OpcLui    = 7'b0110111;
   localparam logic [6:0] OpcAuipc  = 7'b0010111;
   localparam logic [6:0] OpcJal    = 7'b1101111;
   localparam logic [6:0] OpcJalr   = 7'b1100111;

   localparam logic [3:0] AluAdd  = 4'd0;
   localparam logic [3:0] AluSub  = 4'd1;
   localparam logic [3:0] AluAnd  = 4'd2;
   localparam logic [3:0] AluOr   = 4'd3;
   localparam logic [3:0] AluSll  = 4'd4;
   localparam logic [3:0] AluSrl  = 4'd5;
   localparam logic [3:0] AluXor  = 4'd6;
   localparam logic [3:0] AluSlt  = 4'd7;
   localparam logic [3:0] AluSltu = 4'd8;
   localparam logic [3:0] AluSra  = 4'd10;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [3:0]      alu_sel;
      logic            a_sel;
      logic            b_sel;
      logic [XLEN-1:0] imm;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [2:0]      funct3;
      logic            reg_wen;
      logic            mem_rd;
      logic            mem_wr;
      logic            branch;
      logic            jump;
      logic            illegal;
   } bundle_t;

   bundle_t dec;
   bundle_t bundle_d, bundle_q;
   logic    out_valid_d, out_valid_q;

   logic [6:0] opcode;
   logic [2:0] f3;
   logic [6:0] f7;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

   // funct3 -> ALU op for register/immediate ALU ops with funct7 = 0
   function automatic logic [3:0] alu_of_f3(input logic [2:0] sel);
      logic [3:0] r;
      unique case (sel)
         3'd0:    r = AluAdd;
         3'd1:    r = AluSll;
         3'd2:    r = AluSlt;
         3'd3:    r = AluSltu;
         3'd4:    r = AluXor;
         3'd5:    r = AluSrl;
         3'd6:    r = AluOr;
         default: r = AluAnd;
      endcase
      return r;
   endfunction

   // Instruction field extraction and immediate formats
   always_comb begin
      opcode = in_instr[6:0];
      f3     = in_instr[14:12];
      f7     = in_instr[31:25];
      imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
      imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                in_instr[11:8], 1'b0};
      imm_u  = {in_instr[31:12], 12'b0};
      imm_j  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                in_instr[30:21], 1'b0};
      imm_sh = {27'b0, in_instr[24:20]};
   end

   // Combinational decode of the presented instruction
   always_comb begin
      dec        = '0;
      dec.pc     = in_pc;
      dec.rs1    = in_instr[19:15];
      dec.rs2    = in_instr[24:20];
      dec.rd     = in_instr[11:7];
      dec.funct3 = f3;
      case (opcode)
         OpcOp: begin
            dec.reg_wen = 1'b1;
            if (f7 == 7'h00) begin
               dec.alu_sel = alu_of_f3(f3);
            end else if (f7 == 7'h20 && f3 == 3'd0) begin
               dec.alu_sel = AluSub;
            end else if (f7 == 7'h20 && f3 == 3'd5) begin
               dec.alu_sel = AluSra;
            end else begin
               dec.illegal = 1'b1;
            end
         end
         OpcOpImm: begin
            dec.b_sel   = 1'b1;
            dec.reg_wen = 1'b1;
            dec.alu_sel = alu_of_f3(f3);
            dec.imm     = imm_i;
            if (f3 == 3'd1) begin
               dec.imm = imm_sh;
               if (f7 != 7'h00) dec.illegal = 1'b1;
            end else if (f3 == 3'd5) begin
               dec.imm = imm_sh;
               if (f7 == 7'h20) dec.alu_sel = AluSra;
               else if (f7 != 7'h00) dec.illegal = 1'b1;
            end
         end
         OpcLoad: begin
            dec.b_sel   = 1'b1;
            dec.imm     = imm_i;
            dec.mem_rd  = 1'b1;
            dec.reg_wen = 1'b1;
            // Only lb/lh/lw/lbu/lhu exist in RV32I
            if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) dec.illegal = 1'b1;
         end
         OpcStore: begin
            dec.b_sel  = 1'b1;
            dec.imm    = imm_s;
            dec.mem_wr = 1'b1;
            dec.rd     = 5'd0;
            if (f3 > 3'd2) dec.illegal = 1'b1;
         end
         OpcBranch: begin
            dec.a_sel  = 1'b1;
            dec.b_sel  = 1'b1;
            dec.imm    = imm_b;
            dec.branch = 1'b1;
            // rd bits carry immediate here, not a destination
            dec.rd     = 5'd0;
            if (f3 == 3'd2 || f3 == 3'd3) dec.illegal = 1'b1;
         end
         OpcLui: begin
            dec.rs1     = 5'd0;
            dec.b_sel   = 1'b1;
            dec.imm     = imm_u;
            dec.reg_wen = 1'b1;
         end
         OpcAuipc: begin
            dec.a_sel   = 1'b1;
            dec.b_sel   = 1'b1;
            dec.imm     = imm_u;
            dec.reg_wen = 1'b1;
         end
         OpcJal: begin
            dec.a_sel   = 1'b1;
            dec.b_sel   = 1'b1;
            dec.imm     = imm_j;
            dec.jump    = 1'b1;
            dec.reg_wen = 1'b1;
         end
         OpcJalr: begin
            dec.b_sel   = 1'b1;
            dec.imm     = imm_i;
            dec.jump    = 1'b1;
            dec.reg_wen = 1'b1;
            if (f3 != 3'd0) dec.illegal = 1'b1;
         end
         default: dec.illegal = 1'b1;
      endcase
      // Illegal bundles carry only pc and raw fields for the exception path
      if (dec.illegal) begin
         dec.alu_sel = AluAdd;
         dec.a_sel   = 1'b0;
         dec.b_sel   = 1'b0;
         dec.imm     = '0;
         dec.reg_wen = 1'b0;
         dec.mem_rd  = 1'b0;
         dec.mem_wr  = 1'b0;
         dec.branch  = 1'b0;
         dec.jump    = 1'b0;
      end
   end

   assign in_ready = ~out_valid_q | out_ready | flush;

   // Output register next state: flush > transfer > consumed > hold
   always_comb begin
      bundle_d    = bundle_q;
      out_valid_d = out_valid_q;
      if (flush) begin
         out_valid_d = 1'b0;
      end else if (in_valid && in_ready) begin
         bundle_d    = dec;
         out_valid_d = 1'b1;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // Output register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bundle_q    <= '0;
         out_valid_q <= 1'b0;
      end else begin
         bundle_q    <= bundle_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_pc    = bundle_q.pc;
   assign alu_sel   = bundle_q.alu_sel;
   assign a_sel     = bundle_q.a_sel;
   assign b_sel     = bundle_q.b_sel;
   assign imm       = bundle_q.imm;
   assign rs1       = bundle_q.rs1;
   assign rs2       = bundle_q.rs2;
   assign rd        = bundle_q.rd;
   assign funct3    = bundle_q.funct3;
   assign reg_wen   = bundle_q.reg_wen;
   assign mem_rd    = bundle_q.mem_rd;
   assign mem_wr    = bundle_q.mem_wr;
   assign branch    = bundle_q.branch;
   assign jump      = bundle_q.jump;
   assign illegal   = bundle_q.illegal;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Scoreboard bench for rv_decode_stage: directed instructions with
// hand-decoded expected bundles, checked by a monitor on each output transfer.
module tb_rv_decode_stage;

   typedef struct packed {
      logic [31:0] pc;
      logic [3:0]  alu;
      logic        a_sel;
      logic        b_sel;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic [5:0]  flags; // {reg_wen, mem_rd, mem_wr, branch, jump, illegal}
   } bundle_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_instr = '0;
   logic [31:0] in_pc = '0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_pc;
   logic [3:0]  alu_sel;
   logic        a_sel, b_sel;
   logic [31:0] imm;
   logic [4:0]  rs1, rs2, rd;
   logic [2:0]  funct3;
   logic        reg_wen, mem_rd, mem_wr, branch, jump, illegal;

   bundle_t act;
   bundle_t sb[$];
   int      checks = 0;
   int      errors = 0;
   int      cyc = 0;
   int      acc_cyc = 0;

   rv_decode_stage #(.XLEN(32)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_instr (in_instr),
      .in_pc    (in_pc),
      .flush    (flush),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_pc   (out_pc),
      .alu_sel  (alu_sel),
      .a_sel    (a_sel),
      .b_sel    (b_sel),
      .imm      (imm),
      .rs1      (rs1),
      .rs2      (rs2),
      .rd       (rd),
      .funct3   (funct3),
      .reg_wen  (reg_wen),
      .mem_rd   (mem_rd),
      .mem_wr   (mem_wr),
      .branch   (branch),
      .jump     (jump),
      .illegal  (illegal)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign act = '{pc: out_pc, alu: alu_sel, a_sel: a_sel, b_sel: b_sel, imm: imm,
                  rs1: rs1, rs2: rs2, rd: rd, f3: funct3,
                  flags: {reg_wen, mem_rd, mem_wr, branch, jump, illegal}};

   function automatic bundle_t mk(input logic [31:0] pc, input logic [3:0] alu,
                                  input logic a, input logic b, input logic [31:0] im,
                                  input logic [4:0] s1, input logic [4:0] s2,
                                  input logic [4:0] d, input logic [2:0] f,
                                  input logic [5:0] fl);
      bundle_t r;
      r.pc = pc; r.alu = alu; r.a_sel = a; r.b_sel = b; r.imm = im;
      r.rs1 = s1; r.rs2 = s2; r.rd = d; r.f3 = f; r.flags = fl;
      return r;
   endfunction

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, want);
      end
   endtask

   // Present one instruction and wait (bounded) for it to be accepted
   task automatic send(input logic [31:0] instr, input logic [31:0] pc,
                       input bundle_t exp, input bit push);
      bit acc = 1'b0;
      in_valid = 1'b1;
      in_instr = instr;
      in_pc    = pc;
      if (push) sb.push_back(exp);
      for (int n = 0; n < 20 && !acc; n++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
      end
      acc_cyc  = cyc;
      in_valid = 1'b0;
      if (!acc) chk("accept_timeout", 128'(acc), 128'(1));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      bundle_t a_exp;
      int      c0;
      bit      acc;

      fork
         // Monitor: compare every bundle the execute stage consumes
         forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
               if (sb.size() == 0) begin
                  chk("unexpected_bundle", 128'(act), 128'(0));
               end else begin
                  chk($sformatf("bundle_pc_%h", sb[0].pc), 128'(act), 128'(sb[0]));
                  void'(sb.pop_front());
               end
            end
         end
      join_none

      // Reset state
      #3;
      chk("reset_out_valid", 128'(out_valid), 128'(0));
      chk("reset_in_ready", 128'(in_ready), 128'(1));
      chk("reset_bundle", 128'(act), 128'(0));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b1;

      // Main decode vectors
      send(32'h002081B3, 32'h100, mk(32'h100, 4'd0, 0, 0, 32'h0, 5'd1, 5'd2, 5'd3, 3'd0, 6'b100000), 1);
      send(32'h407302B3, 32'h104, mk(32'h104, 4'd1, 0, 0, 32'h0, 5'd6, 5'd7, 5'd5, 3'd0, 6'b100000), 1);
      c0 = acc_cyc;
      send(32'h40325213, 32'h108, mk(32'h108, 4'd10, 0, 1, 32'h3, 5'd4, 5'd3, 5'd4, 3'd5, 6'b100000), 1);
      chk("no_bubble", 128'(acc_cyc - c0), 128'(1));
      send(32'hFFC12083, 32'h10C, mk(32'h10C, 4'd0, 0, 1, 32'hFFFFFFFC, 5'd2, 5'd28, 5'd1, 3'd2, 6'b110000), 1);
      send(32'h00512423, 32'h110, mk(32'h110, 4'd0, 0, 1, 32'h8, 5'd2, 5'd5, 5'd0, 3'd2, 6'b001000), 1);
      send(32'hFE208CE3, 32'h114, mk(32'h114, 4'd0, 1, 1, 32'hFFFFFFF8, 5'd1, 5'd2, 5'd0, 3'd0, 6'b000100), 1);
      send(32'h123453B7, 32'h118, mk(32'h118, 4'd0, 0, 1, 32'h12345000, 5'd0, 5'd3, 5'd7, 3'd5, 6'b100000), 1);
      send(32'h010000EF, 32'h11C, mk(32'h11C, 4'd0, 1, 1, 32'h10, 5'd0, 5'd16, 5'd1, 3'd0, 6'b100010), 1);
      send(32'h00008067, 32'h120, mk(32'h120, 4'd0, 0, 1, 32'h0, 5'd1, 5'd0, 5'd0, 3'd0, 6'b100010), 1);
      send(32'hFFF00113, 32'h124, mk(32'h124, 4'd0, 0, 1, 32'hFFFFFFFF, 5'd0, 5'd31, 5'd2, 3'd0, 6'b100000), 1);
      idle(1);

      // Back-pressure: held bundle stays stable while a new one waits
      out_ready = 1'b0;
      a_exp = mk(32'h200, 4'd0, 0, 0, 32'h0, 5'd1, 5'd2, 5'd3, 3'd0, 6'b100000);
      send(32'h002081B3, 32'h200, a_exp, 1);
      in_valid = 1'b1;
      in_instr = 32'h407302B3;
      in_pc    = 32'h204;
      sb.push_back(mk(32'h204, 4'd1, 0, 0, 32'h0, 5'd6, 5'd7, 5'd5, 3'd0, 6'b100000));
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("bp_in_ready_%0d", k), 128'(in_ready), 128'(0));
         chk($sformatf("bp_out_valid_%0d", k), 128'(out_valid), 128'(1));
         chk($sformatf("bp_hold_%0d", k), 128'(act), 128'(a_exp));
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("bp_release_accept", 128'(acc), 128'(1));
      idle(1);

      // Flush with coincident input drops it
      in_valid = 1'b1;
      in_instr = 32'h002081B3;
      in_pc    = 32'h300;
      flush    = 1'b1;
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("flush_in_dropped", 128'(out_valid), 128'(0));
      @(posedge clk);
      #1;
      send(32'h002081B3, 32'h304, mk(32'h304, 4'd0, 0, 0, 32'h0, 5'd1, 5'd2, 5'd3, 3'd0, 6'b100000), 1);
      idle(1);

      // Flush drops a bundle held under back-pressure
      out_ready = 1'b0;
      send(32'h002081B3, 32'h400, a_exp, 0);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      @(negedge clk);
      chk("flush_held_dropped", 128'(out_valid), 128'(0));
      @(posedge clk);
      #1;
      out_ready = 1'b1;

      // Illegal encodings still produce a valid bundle
      send(32'hFFFFFFFF, 32'h500, mk(32'h500, 4'd0, 0, 0, 32'h0, 5'd31, 5'd31, 5'd31, 3'd7, 6'b000001), 1);
      send(32'h40109093, 32'h504, mk(32'h504, 4'd0, 0, 0, 32'h0, 5'd1, 5'd1, 5'd1, 3'd1, 6'b000001), 1);
      idle(1);

      // Asynchronous reset mid-stream
      out_ready = 1'b0;
      send(32'h002081B3, 32'h508, a_exp, 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_out_valid", 128'(out_valid), 128'(0));
      chk("async_rst_in_ready", 128'(in_ready), 128'(1));
      chk("async_rst_bundle", 128'(act), 128'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      send(32'h00512423, 32'h600, mk(32'h600, 4'd0, 0, 1, 32'h8, 5'd2, 5'd5, 5'd0, 3'd2, 6'b001000), 1);
      idle(3);

      chk("scoreboard_drained", 128'(sb.size()), 128'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
